gate_vector_sequencer: RTL and testbench

//   Self-checking stimulus controller for a 2-input combinational gate.

---
 rtl/gate_vector_sequencer_pkg.sv | 17 +
 rtl/gate_vector_sequencer_hold_timer.sv | 27 ++
 rtl/gate_vector_sequencer.sv | 107 ++++++++++
 tb/tb_gate_vector_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/gate_vector_sequencer_pkg.sv
// rtl/gate_vector_sequencer_pkg.sv - shared state encoding and reference truth tables
package gate_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit k is the gate output expected for {a,b} == k
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_vector_sequencer_hold_timer.sv
// rtl/gate_vector_sequencer_hold_timer.sv - terminal-count hold counter with clear/enable
module hold_timer #(
    parameter int         W    = 4,
    parameter logic [W-1:0] TERM = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - sweeps a 2-input gate through all vectors and checks it
module gate_vector_sequencer
    import gate_vector_sequencer_pkg::*;
#(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] EXP_TABLE   = TT_AND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_out,
    output logic       vec_a,
    output logic       vec_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);

    localparam int             CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  TERM = CW'(HOLD_CYCLES - 2);

    state_t     state_q;
    logic [1:0] vec_q;
    logic       busy_q, done_q, pass_q;
    logic [3:0] err_mask_q;
    logic [2:0] err_count_q;

    logic       start_accept;
    logic       hold_tc;
    logic       mismatch_d;
    logic [3:0] err_mask_d;
    logic [2:0] err_count_d;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Last DRIVE cycle is reached at HOLD_CYCLES-2, so with SAMPLE each vector lasts HOLD_CYCLES clocks
    hold_timer #(
        .W    (CW),
        .TERM (TERM)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_accept || (state_q == SAMPLE)),
        .en_i  (state_q == DRIVE),
        .tc_o  (hold_tc)
    );

    assign mismatch_d  = gate_out ^ EXP_TABLE[vec_q];
    assign err_mask_d  = err_mask_q | ({3'b000, mismatch_d} << vec_q);
    assign err_count_d = err_count_q + {2'b00, mismatch_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_mask_q  <= 4'd0;
            err_count_q <= 3'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= DRIVE;
                        vec_q       <= 2'd0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_mask_q  <= 4'd0;
                        err_count_q <= 3'd0;
                    end
                end
                DRIVE: begin
                    if (hold_tc) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_mask_q  <= err_mask_d;
                    err_count_q <= err_count_d;
                    if (vec_q == 2'd3) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_mask_d == 4'd0);
                    end else begin
                        state_q <= DRIVE;
                        vec_q   <= vec_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_a     = vec_q[1];
    assign vec_b     = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb/tb_gate_vector_sequencer.sv - directed bench for gate_vector_sequencer
module tb_gate_vector_sequencer;
    import gate_vector_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       or_mode;

    logic       a_va, a_vb, a_busy, a_done, a_pass, a_gate;
    logic [3:0] a_mask;
    logic [2:0] a_cnt;
    logic       x_va, x_vb, x_busy, x_done, x_pass;
    logic [3:0] x_mask;
    logic [2:0] x_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate under control: AND, or OR when or_mode is set
    assign a_gate = or_mode ? (a_va | a_vb) : (a_va & a_vb);

    gate_vector_sequencer #(.HOLD_CYCLES(10), .EXP_TABLE(TT_AND)) u_and (
        .clk(clk), .rst(rst), .start(start), .gate_out(a_gate),
        .vec_a(a_va), .vec_b(a_vb), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_mask(a_mask), .err_count(a_cnt)
    );

    // Stuck-at-1 gate against an XOR table
    gate_vector_sequencer #(.HOLD_CYCLES(10), .EXP_TABLE(TT_XOR)) u_xor (
        .clk(clk), .rst(rst), .start(start), .gate_out(1'b1),
        .vec_a(x_va), .vec_b(x_vb), .busy(x_busy), .done(x_done),
        .pass(x_pass), .err_mask(x_mask), .err_count(x_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start, then walks the 40-clock sweep checking {vec_a,vec_b,busy,done} every clock
    task automatic sweep(input int restart_at);
        logic [1:0] ev;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("accept_state", {4'd0, a_va, a_vb, a_busy, a_done}, 8'h02);
        chk("accept_mask",  {4'd0, a_mask}, 8'h00);
        chk("accept_count", {5'd0, a_cnt},  8'h00);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == restart_at) start = 1'b1;
            tick(1);
            start = 1'b0;
            ev = (cyc < 40) ? 2'(cyc / 10) : 2'd3;
            chk($sformatf("sweep_cyc%0d", cyc), {4'd0, a_va, a_vb, a_busy, a_done},
                {4'd0, ev, 1'(cyc < 40), 1'(cyc == 40)});
        end
    endtask

    task automatic results(input string tag, input logic [3:0] em, input logic [2:0] ec, input logic ep);
        chk({tag, "_and_mask"},  {4'd0, a_mask}, {4'd0, em});
        chk({tag, "_and_count"}, {5'd0, a_cnt},  {5'd0, ec});
        chk({tag, "_and_pass"},  {7'd0, a_pass}, {7'd0, ep});
        chk({tag, "_xor_mask"},  {4'd0, x_mask}, 8'h09);
        chk({tag, "_xor_count"}, {5'd0, x_cnt},  8'h02);
        chk({tag, "_xor_pass"},  {7'd0, x_pass, x_done}, 8'h01);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        or_mode = 1'b0;
        tick(2);
        chk("reset_outputs", {a_va, a_vb, a_busy, a_done, a_pass, a_cnt}, 8'h00);
        chk("reset_mask",    {4'd0, a_mask}, 8'h00);
        rst = 1'b0;
        tick(2);
        chk("idle_outputs",  {a_va, a_vb, a_busy, a_done, a_pass, a_cnt}, 8'h00);

        // Matching AND gate
        sweep(0);
        results("and_ok", 4'b0000, 3'd0, 1'b1);

        // OR gate checked against AND table
        or_mode = 1'b1;
        sweep(0);
        results("or_wired", 4'b0110, 3'd2, 1'b0);
        tick(5);
        chk("done_held", {4'd0, a_va, a_vb, a_busy, a_done}, 8'h0D);

        // Restart from DONE after a failing run
        or_mode = 1'b0;
        sweep(0);
        results("rerun", 4'b0000, 3'd0, 1'b1);

        // start mid-sweep is ignored
        sweep(15);
        results("restart_ignored", 4'b0000, 3'd0, 1'b1);

        // Reset 22 clocks into a failing sweep
        or_mode = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(22);
        chk("partial_mask",  {4'd0, a_mask}, 8'h02);
        chk("partial_vec",   {6'd0, a_va, a_vb}, 8'h02);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {a_va, a_vb, a_busy, a_done, a_pass, a_cnt}, 8'h00);
        chk("midrst_mask",    {4'd0, a_mask}, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("post_rst_idle",  {4'd0, a_va, a_vb, a_busy, a_done}, 8'h00);
        or_mode = 1'b0;
        sweep(0);
        results("after_rst", 4'b0000, 3'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
